// File: rtl/tt_um_word_serializer_if.sv
// Byte-bus bundle for the word serializer.
// Host side drives ena/ui_in/uio_in and observes the outputs.
interface tt_um_word_serializer_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_word_serializer.sv
// 32-bit parallel-to-serial transmitter, MSB first.
// Separate holding and shift registers allow back-to-back words.
module tt_um_word_serializer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  tt_um_word_serializer_if.slave bus
);

  localparam logic [7:0] DLAST = 8'(DIV - 1);

  logic [31:0] hold_q, hold_d;
  logic [31:0] shreg_q, shreg_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  divcnt_q, divcnt_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        done_q, done_d;

  logic wr, go, clr;
  logic full, wrap, ending, go_acc;
  logic unused_ok;

  assign wr  = bus.uio_in[0];
  assign go  = bus.uio_in[1];
  assign clr = bus.uio_in[2];
  assign unused_ok = ^bus.uio_in[7:3];

  assign full   = (ptr_q == 3'd4);
  assign wrap   = (divcnt_q == DLAST);
  assign ending = busy_q && (bitcnt_q == 5'd31) && wrap;
  assign go_acc = go && full && !clr && (!busy_q || ending);

  // Next-state: byte loading, go acceptance and bit shifting.
  always_comb begin
    hold_d   = hold_q;
    shreg_d  = shreg_q;
    ptr_d    = ptr_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
    done_d   = ending;

    if (clr) begin
      ovr_d = 1'b0;
      ptr_d = 3'd0;
      if (wr) begin
        hold_d[31:24] = bus.ui_in;
        ptr_d = 3'd1;
      end
    end else if (go_acc) begin
      ptr_d = 3'd0;
      if (wr) begin
        hold_d[31:24] = bus.ui_in;
        ptr_d = 3'd1;
      end
    end else if (wr) begin
      unique case (ptr_q)
        3'd0: hold_d[31:24] = bus.ui_in;
        3'd1: hold_d[23:16] = bus.ui_in;
        3'd2: hold_d[15:8]  = bus.ui_in;
        3'd3: hold_d[7:0]   = bus.ui_in;
        default: ovr_d = 1'b1;
      endcase
      if (!full) ptr_d = ptr_q + 3'd1;
    end

    if (go_acc) begin
      shreg_d  = hold_q;
      bitcnt_d = 5'd0;
      divcnt_d = 8'd0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (wrap) begin
        divcnt_d = 8'd0;
        shreg_d  = {shreg_q[30:0], 1'b0};
        bitcnt_d = bitcnt_q + 5'd1;
        if (ending) busy_d = 1'b0;
      end else begin
        divcnt_d = divcnt_q + 8'd1;
      end
    end
  end

  // State registers; everything freezes while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      shreg_q  <= '0;
      ptr_q    <= '0;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.ena) begin
      hold_q   <= hold_d;
      shreg_q  <= shreg_d;
      ptr_q    <= ptr_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
      done_q   <= done_d;
    end
  end

  assign bus.uo_out = {
    busy_q ? bitcnt_q : 5'd0,
    busy_q && (divcnt_q == 8'd0),
    busy_q,
    busy_q && shreg_q[31]
  };
  assign bus.uio_out = {ovr_q, done_q, full, busy_q, 4'b0000};
  assign bus.uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_word_serializer.sv
// Bench for the word serializer: DIV=1 and DIV=4 instances,
// random words checked against a per-cycle bit-timing model.
module tb_tt_um_word_serializer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       ena_v [2];
  logic [7:0] ui_v  [2];
  logic       wr_v  [2];
  logic       go_v  [2];
  logic       clr_v [2];

  tt_um_word_serializer_if b1 ();
  tt_um_word_serializer_if b4 ();

  assign b1.ena    = ena_v[0];
  assign b1.ui_in  = ui_v[0];
  assign b1.uio_in = {5'd0, clr_v[0], go_v[0], wr_v[0]};
  assign b4.ena    = ena_v[1];
  assign b4.ui_in  = ui_v[1];
  assign b4.uio_in = {5'd0, clr_v[1], go_v[1], wr_v[1]};

  tt_um_word_serializer #(.DIV(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1)
  );

  tt_um_word_serializer #(.DIV(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b4)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] uo(int s);
    return (s == 0) ? b1.uo_out : b4.uo_out;
  endfunction

  function automatic logic [7:0] uio(int s);
    return (s == 0) ? b1.uio_out : b4.uio_out;
  endfunction

  function automatic logic [7:0] oe(int s);
    return (s == 0) ? b1.uio_oe : b4.uio_oe;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbyte(int s, logic [7:0] b);
    wr_v[s] = 1'b1;
    ui_v[s] = b;
    tick();
    wr_v[s] = 1'b0;
  endtask

  task automatic load(int s, logic [31:0] w);
    for (int i = 0; i < 4; i++) wbyte(s, w[31 - 8 * i -: 8]);
  endtask

  task automatic start(int s);
    go_v[s] = 1'b1;
    tick();
    go_v[s] = 1'b0;
  endtask

  // Model: cycle t after acceptance carries bit k = t/div of w,
  // strobe on the first cycle of each bit, frame high throughout.
  task automatic run_word(int s, int div, logic [31:0] w, bit b2b,
                          bit do_next, logic [31:0] wn,
                          int pause_t, int pause_n);
    for (int t = 0; t < 32 * div; t++) begin
      int k;
      logic [7:0] e;
      logic [7:0] u;
      k = t / div;
      e = {5'(k), 1'((t % div) == 0), 1'b1, w[31 - k]};
      chk($sformatf("uo s%0d t%0d", s, t), 32'(uo(s)), 32'(e));
      u = uio(s);
      chk($sformatf("done_busy s%0d t%0d", s, t),
          32'({u[6], u[4]}), 32'({b2b && (t == 0), 1'b1}));
      if (t == pause_t) begin
        ena_v[s] = 1'b0;
        for (int p = 0; p < pause_n; p++) begin
          tick();
          chk($sformatf("hold s%0d t%0d p%0d", s, t, p),
              32'(uo(s)), 32'(e));
        end
        ena_v[s] = 1'b1;
      end
      if (do_next) begin
        if (t < 4) begin
          wr_v[s] = 1'b1;
          ui_v[s] = wn[31 - 8 * t -: 8];
        end else begin
          wr_v[s] = 1'b0;
          go_v[s] = 1'b1;
        end
      end
      tick();
    end
    wr_v[s] = 1'b0;
  endtask

  task automatic finish_idle(int s, bit ovr, bit full);
    chk($sformatf("end uo s%0d", s), 32'(uo(s)), 32'h0);
    chk($sformatf("end uio s%0d", s), 32'(uio(s)),
        32'({ovr, 1'b1, full, 1'b0, 4'b0}));
    tick();
    chk($sformatf("post uio s%0d", s), 32'(uio(s)),
        32'({ovr, 1'b0, full, 1'b0, 4'b0}));
  endtask

  initial begin
    logic [31:0] w1, w2, w3;
    logic [7:0]  x, u;
    for (int s = 0; s < 2; s++) begin
      ena_v[s] = 1'b1;
      ui_v[s]  = 8'h00;
      wr_v[s]  = 1'b0;
      go_v[s]  = 1'b0;
      clr_v[s] = 1'b0;
    end
    rst_n = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst uo s%0d", s), 32'(uo(s)), 32'h0);
      chk($sformatf("rst uio s%0d", s), 32'(uio(s)), 32'h0);
      chk($sformatf("rst oe s%0d", s), 32'(oe(s)), 32'hF0);
    end
    rst_n = 1'b1;
    tick();

    // basic word, DIV=1
    load(0, 32'hA53C0FF0);
    u = uio(0);
    chk("full after 4", 32'(u[5]), 32'h1);
    start(0);
    run_word(0, 1, 32'hA53C0FF0, 0, 0, 0, -1, 0);
    finish_idle(0, 0, 0);

    // basic word and random word with ena pause, DIV=4
    load(1, 32'hA53C0FF0);
    start(1);
    run_word(1, 4, 32'hA53C0FF0, 0, 0, 0, -1, 0);
    finish_idle(1, 0, 0);
    w1 = $urandom;
    load(1, w1);
    start(1);
    run_word(1, 4, w1, 0, 0, 0, 21, 5);
    finish_idle(1, 0, 0);

    // overlap and back-to-back, DIV=1
    for (int i = 0; i < 3; i++) begin
      w1 = $urandom;
      w2 = (i == 0) ? 32'h12345678 : $urandom;
      load(0, w1);
      start(0);
      run_word(0, 1, w1, 0, 1, w2, -1, 0);
      go_v[0] = 1'b0;
      run_word(0, 1, w2, 1, 0, 0, -1, 0);
      finish_idle(0, 0, 0);
    end

    // rejects and overrun
    w1 = $urandom;
    wbyte(0, w1[31:24]);
    wbyte(0, w1[23:16]);
    wbyte(0, w1[15:8]);
    u = uio(0);
    chk("full at 3", 32'(u[5]), 32'h0);
    start(0);
    chk("go ptr3 uo", 32'(uo(0)), 32'h0);
    u = uio(0);
    chk("go ptr3 busy", 32'(u[4]), 32'h0);
    wbyte(0, w1[7:0]);
    u = uio(0);
    chk("full ovr0", 32'({u[7], u[5]}), 32'h1);
    wbyte(0, ~w1[7:0]);
    u = uio(0);
    chk("ovr set", 32'({u[7], u[5]}), 32'h3);
    start(0);
    run_word(0, 1, w1, 0, 0, 0, -1, 0);
    finish_idle(0, 1, 0);

    load(0, $urandom);
    clr_v[0] = 1'b1;
    go_v[0]  = 1'b1;
    tick();
    clr_v[0] = 1'b0;
    go_v[0]  = 1'b0;
    chk("clr+go uo", 32'(uo(0)), 32'h0);
    chk("clr+go uio", 32'(uio(0)), 32'h0);

    // clr with wr, then go with wr
    x  = 8'($urandom);
    w3 = $urandom;
    w3[31:24] = x;
    clr_v[0] = 1'b1;
    wbyte(0, x);
    clr_v[0] = 1'b0;
    wbyte(0, w3[23:16]);
    wbyte(0, w3[15:8]);
    u = uio(0);
    chk("clr+wr ptr3", 32'(u[5]), 32'h0);
    wbyte(0, w3[7:0]);
    u = uio(0);
    chk("clr+wr full", 32'(u[5]), 32'h1);
    go_v[0] = 1'b1;
    wbyte(0, 8'hEE);
    go_v[0] = 1'b0;
    run_word(0, 1, w3, 0, 0, 0, -1, 0);
    finish_idle(0, 0, 0);
    w2 = $urandom;
    w2[31:24] = 8'hEE;
    wbyte(0, w2[23:16]);
    wbyte(0, w2[15:8]);
    wbyte(0, w2[7:0]);
    start(0);
    run_word(0, 1, w2, 0, 0, 0, -1, 0);
    finish_idle(0, 0, 0);

    // asynchronous reset mid-word
    w1 = $urandom;
    load(1, w1);
    start(1);
    repeat (10) tick();
    u = uo(1);
    chk("frame before rst", 32'(u[1]), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst uo", 32'(uo(1)), 32'h0);
    u = uio(1);
    chk("async rst uio", 32'(u[7:4]), 32'h0);
    chk("async rst oe", 32'(oe(1)), 32'hF0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("after rst uo", 32'(uo(1)), 32'h0);
    chk("after rst uio", 32'(uio(1)), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
